mmio_ctl: RTL and testbench
===========================

// Module: mmio_ctl
// PURPOSE
// - Parametrised memory/IO controller between the eLC-3 datapath and the DE2-115 SRAM and board IO.
// - Decodes the top-of-memory IO page: KBSR, KBDR, DSR and N_DISP display data registers.
// - Sequences SRAM accesses with a configurable wait-state count and returns a Ready pulse per access.
// PARAMETERS
// - DATA_W      16      data width: CPU bus, SRAM_DQ and every IO register
// - ADDR_W      16      CPU address width
// - SRAM_AW     20      SRAM address width; Addr is zero-extended onto it
// - N_DISP      1       number of display data registers DDR0..DDR(N_DISP-1), 1..8
// - WAIT_STATES 2       extra SRAM access cycles, 0..15
// - DDR_BASE    16'hFE06 address of DDR0; DDRi is at DDR_BASE+i
// PORTS
// - Clk          in   1              system clock
// - Reset_N      in   1              synchronous reset, active low
// - Req          in   1              access request (MIO_EN); held until Ready
// - R_W          in   1              1 = write, 0 = read
// - Addr         in   ADDR_W         access address
// - Wdata        in   DATA_W         write data
// - Rdata        out  DATA_W         read data, valid with Ready
// - Ready        out  1              one-cycle access-complete pulse
// - Kbd_Data     in   DATA_W         synchronized keyboard/switch value
// - Kbd_Strobe   in   1              one-cycle pulse: new key available
// - Disp_Out     out  N_DISP*DATA_W  DDRi on bits [i*DATA_W +: DATA_W]
// - Kbd_Irq      out  1              keyboard interrupt (MMIO_KBD_IRQ_EN only)
// - SRAM_ADDR    out  SRAM_AW        SRAM address
// - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out 1 each, active-low SRAM controls
// - SRAM_DQ      inout DATA_W        SRAM data, driven only during write access
// BEHAVIOUR
// - One clock and one reset: Clk with Reset_N, synchronous, active low; no other clock or reset.
// - Map: FE00 KBSR, FE02 KBDR, FE04 DSR, DDR_BASE+i DDRi; other addrs >= FE00 read 0, writes dropped; < FE00 go to SRAM.
// - Reset: FSM IDLE, Ready 0, Rdata 0, KBSR/KBDR/DDRi 0, all SRAM_*_N 1, SRAM_DQ Z, SRAM_ADDR 0.
// - FSM: IDLE -> (Req & IO addr) DONE; IDLE -> (Req & SRAM addr) ACC; ACC holds WAIT_STATES+1 cycles -> DONE; DONE -> IDLE.
// - Accept only in IDLE; Addr/Wdata/R_W registered at accept; Req high in IDLE after DONE starts a new access.
// - Latency from accept cycle T: IO Ready at T+1; SRAM Ready at T+2+WAIT_STATES.
// - ACC: CE_N=LB_N=UB_N=0; read OE_N=0, WE_N=1; write WE_N=0, OE_N=1, DQ driven with Wdata; read data captured on last ACC cycle.
// - Rdata updates only on read completion; holds until the next read completes.
// - Kbd_Strobe: KBDR<=Kbd_Data, KBSR[15]<=1; strobe while KBSR[15]=1 also sets overrun KBSR[13].
// - KBDR read: clears KBSR[15] and KBSR[13] in the DONE cycle; strobe in the same cycle wins (KBSR[15]=1, new data, KBSR[13]=0).
// - DSR reads 16'h8000 (display always ready); KBSR/KBDR/DSR writes ignored except as below; Ready still pulses.
// - DDRi write takes effect in DONE cycle; Disp_Out reflects it the following cycle.
// - Reset mid-access: access abandoned, no Ready, controls deassert that cycle; write may be partial in SRAM.
// CONFIGURATION
// - MMIO_KBD_IRQ_EN defined: KBSR[14] is read/write interrupt enable (write sets from Wdata[14]); Kbd_Irq = KBSR[15]&KBSR[14], reset 0.
// - MMIO_KBD_IRQ_EN undefined: KBSR[14] reads 0, writes ignored; Kbd_Irq port absent.
// TESTING
// - Reset_N=0 2 cycles with Req=1 -> Ready 0, SRAM_CE_N=1, DQ Z, Disp_Out 0, KBSR reads 0000.
// - WAIT_STATES=2, write 3000<-BEEF then read 3000 -> WE_N low 3 cycles, Ready at T+4 each, Rdata=BEEF.
// - Kbd_Data=0041, strobe; read FE00 -> 8000; read FE02 -> 0041 with Ready at T+1; read FE00 -> 0000.
// - Two strobes without KBDR read -> KBSR=A000; KBDR read coinciding with third strobe -> KBSR=8000, KBDR=third value.
// - N_DISP=2: write FE07<-1234 -> Disp_Out[31:16]=1234, [15:0] unchanged; read FE04 -> 8000; read FE20 -> 0000.
// - MMIO_KBD_IRQ_EN: write FE00<-4000, strobe -> Kbd_Irq=1; KBDR read -> Kbd_Irq=0, KBSR=4000.

Source files
------------

// File: rtl/mmio_ctl.sv
// mmio_ctl: eLC-3 memory/IO controller, SRAM sequencing with wait states plus the top-of-memory IO page.
// Define MMIO_KBD_IRQ_EN to add the KBSR interrupt-enable bit and the Kbd_Irq output.
module mmio_ctl #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                SRAM_AW     = 20,
    parameter int                N_DISP      = 1,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] DDR_BASE    = 16'hFE06
) (
    input  logic                     Clk,
    input  logic                     Reset_N,
    input  logic                     Req,
    input  logic                     R_W,
    input  logic [ADDR_W-1:0]        Addr,
    input  logic [DATA_W-1:0]        Wdata,
    output logic [DATA_W-1:0]        Rdata,
    output logic                     Ready,
    input  logic [DATA_W-1:0]        Kbd_Data,
    input  logic                     Kbd_Strobe,
    output logic [N_DISP*DATA_W-1:0] Disp_Out,
`ifdef MMIO_KBD_IRQ_EN
    output logic                     Kbd_Irq,
`endif
    output logic [SRAM_AW-1:0]       SRAM_ADDR,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_LB_N,
    output logic                     SRAM_UB_N,
    inout  wire  [DATA_W-1:0]        SRAM_DQ
);

    localparam logic [ADDR_W-1:0] IO_BASE = {ADDR_W{1'b1}} << 9;
    localparam logic [ADDR_W-1:0] KBSR_A  = IO_BASE;
    localparam logic [ADDR_W-1:0] KBDR_A  = IO_BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] DSR_A   = IO_BASE + ADDR_W'(4);
    localparam int KB_RDY = DATA_W - 1;
    localparam int KB_IE  = DATA_W - 2;
    localparam int KB_OVR = DATA_W - 3;
    localparam logic [DATA_W-1:0] DSR_VAL   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [DATA_W-1:0]              wdata_q, wdata_d;
    logic                           rw_q, rw_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic                           ready_q, ready_d;
    logic [DATA_W-1:0]              rdata_q, rdata_d;
    logic [SRAM_AW-1:0]             sram_addr_q, sram_addr_d;
    logic                           ce_n_q, ce_n_d;
    logic                           oe_n_q, oe_n_d;
    logic                           we_n_q, we_n_d;
    logic                           be_n_q, be_n_d;
    logic                           dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0]              kbsr_q, kbsr_d;
    logic [DATA_W-1:0]              kbdr_q, kbdr_d;
    logic [N_DISP-1:0][DATA_W-1:0]  ddr_q, ddr_d;
    logic [DATA_W-1:0]              io_rdata;
    logic                           kb_clr;

    // IO register side effects all land at the end of the DONE cycle; a key strobe beats a KBDR read.
    always_comb begin
        kbsr_d = kbsr_q;
        kbdr_d = kbdr_q;
        ddr_d  = ddr_q;
        kb_clr = (state_q == S_DONE) && !rw_q && (addr_q == KBDR_A);
        if (kb_clr) begin
            kbsr_d[KB_RDY] = 1'b0;
            kbsr_d[KB_OVR] = 1'b0;
        end
`ifdef MMIO_KBD_IRQ_EN
        if ((state_q == S_DONE) && rw_q && (addr_q == KBSR_A))
            kbsr_d[KB_IE] = wdata_q[KB_IE];
`endif
        if (Kbd_Strobe) begin
            kbdr_d         = Kbd_Data;
            kbsr_d[KB_RDY] = 1'b1;
            if (kbsr_q[KB_RDY] && !kb_clr)
                kbsr_d[KB_OVR] = 1'b1;
        end
        for (int i = 0; i < N_DISP; i++) begin
            if ((state_q == S_DONE) && rw_q && (addr_q == DDR_BASE + ADDR_W'(i)))
                ddr_d[i] = wdata_q;
        end
    end

    // IO read data uses next-state register values so a same-cycle strobe is not lost by the read.
    always_comb begin
        io_rdata = '0;
        if (Addr == KBSR_A)
            io_rdata = kbsr_d;
        else if (Addr == KBDR_A)
            io_rdata = kbdr_d;
        else if (Addr == DSR_A)
            io_rdata = DSR_VAL;
        for (int i = 0; i < N_DISP; i++) begin
            if (Addr == DDR_BASE + ADDR_W'(i))
                io_rdata = ddr_d[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        be_n_d      = be_n_q;
        dq_oe_d     = dq_oe_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d  = Addr;
                    wdata_d = Wdata;
                    rw_d    = R_W;
                    if (Addr >= IO_BASE) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                        if (!R_W)
                            rdata_d = io_rdata;
                    end else begin
                        state_d     = S_ACC;
                        cnt_d       = WAIT_INIT;
                        sram_addr_d = SRAM_AW'(Addr);
                        ce_n_d      = 1'b0;
                        be_n_d      = 1'b0;
                        oe_n_d      = R_W;
                        we_n_d      = !R_W;
                        dq_oe_d     = R_W;
                    end
                end
            end
            S_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    ce_n_d  = 1'b1;
                    be_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (!rw_q)
                        rdata_d = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            kbsr_q      <= '0;
            kbdr_q      <= '0;
            ddr_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            dq_oe_q     <= dq_oe_d;
            kbsr_q      <= kbsr_d;
            kbdr_q      <= kbdr_d;
            ddr_q       <= ddr_d;
        end
    end

    assign Rdata     = rdata_q;
    assign Ready     = ready_q;
    assign Disp_Out  = ddr_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_LB_N = be_n_q;
    assign SRAM_UB_N = be_n_q;
    assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
`ifdef MMIO_KBD_IRQ_EN
    assign Kbd_Irq   = kbsr_q[KB_RDY] & kbsr_q[KB_IE];
`endif

endmodule

// File: tb/tb_mmio_ctl.sv
// tb_mmio_ctl: scoreboard bench for mmio_ctl with N_DISP=2, WAIT_STATES=2 and a small SRAM model.
// Kbd_Irq checks are compiled in when MMIO_KBD_IRQ_EN is defined.
module tb_mmio_ctl;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        Req;
    logic        R_W;
    logic [15:0] Addr;
    logic [15:0] Wdata;
    logic [15:0] Rdata;
    logic        Ready;
    logic [15:0] Kbd_Data;
    logic        Kbd_Strobe;
    logic [31:0] Disp_Out;
`ifdef MMIO_KBD_IRQ_EN
    logic        Kbd_Irq;
`endif
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
    wire  [15:0] sram_dq;

    mmio_ctl #(
        .DATA_W(16), .ADDR_W(16), .SRAM_AW(20), .N_DISP(2), .WAIT_STATES(2), .DDR_BASE(16'hFE06)
    ) dut (
        .Clk(Clk), .Reset_N(Reset_N), .Req(Req), .R_W(R_W), .Addr(Addr), .Wdata(Wdata),
        .Rdata(Rdata), .Ready(Ready), .Kbd_Data(Kbd_Data), .Kbd_Strobe(Kbd_Strobe),
        .Disp_Out(Disp_Out),
`ifdef MMIO_KBD_IRQ_EN
        .Kbd_Irq(Kbd_Irq),
`endif
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N),
        .SRAM_DQ(sram_dq)
    );

    always #5 Clk = ~Clk;

    // Asynchronous-read SRAM model; byte enables must be low for a write to land.
    logic [15:0] mem [0:255];
    always @(posedge Clk)
        if (!SRAM_CE_N && !SRAM_WE_N && !SRAM_LB_N && !SRAM_UB_N)
            mem[SRAM_ADDR[7:0]] <= sram_dq;
    assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

    typedef struct {
        string       name;
        logic [15:0] rdata;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    logic [15:0] last_rd = 16'h0000;
    int          we_cnt = 0;
    int          dq_ok_cnt = 0;
    logic [15:0] we_expect = 16'h0000;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Ready pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL unexpected_ready: got Ready=1 at cycle %0d, expected no access", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_rdata"}, {16'h0, Rdata}, {16'h0, e.rdata});
                checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
            end
        end
        if (SRAM_WE_N === 1'b0) begin
            we_cnt++;
            if (sram_dq === we_expect) dq_ok_cnt++;
        end
    end

    task automatic applyStimulus(input string name, input logic rw, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expd, input int lat,
                                 input logic strobe_in_done, input logic [15:0] strobe_val);
        exp_t e;
        bit   seen = 1'b0;
        @(negedge Clk);
        Req   = 1'b1;
        R_W   = rw;
        Addr  = addr;
        Wdata = wdata;
        e.name  = name;
        e.rdata = rw ? last_rd : expd;
        e.lat   = lat;
        e.issue = cyc;
        sb.push_back(e);
        if (!rw) last_rd = expd;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge Clk);
            if (k == 0 && strobe_in_done) begin
                Kbd_Strobe = 1'b1;
                Kbd_Data   = strobe_val;
            end else begin
                Kbd_Strobe = 1'b0;
            end
            if (Ready === 1'b1) begin
                seen = 1'b1;
                Req  = 1'b0;
            end
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL %s_timeout: got no Ready in 40 cycles, expected Ready", name);
            Req = 1'b0;
        end
        if (strobe_in_done) begin
            @(negedge Clk);
            Kbd_Strobe = 1'b0;
        end
    endtask

    task automatic pulseStrobe(input logic [15:0] v);
        @(negedge Clk);
        Kbd_Strobe = 1'b1;
        Kbd_Data   = v;
        @(negedge Clk);
        Kbd_Strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        Reset_N = 1'b0; Req = 1'b1; R_W = 1'b0; Addr = 16'hFE00; Wdata = 16'h0000;
        Kbd_Data = 16'h0000; Kbd_Strobe = 1'b0;

        // Reset held two cycles with a pending request
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            checkOutput("reset_ready", {31'h0, Ready}, 32'h0);
            checkOutput("reset_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
        end
        checkOutput("reset_we_oe", {30'h0, SRAM_WE_N, SRAM_OE_N}, 32'h3);
        checkOutput("reset_disp", Disp_Out, 32'h0);
        checkOutput("reset_sram_addr", {12'h0, SRAM_ADDR}, 32'h0);
        checkOutput("reset_rdata", {16'h0, Rdata}, 32'h0);
`ifdef MMIO_KBD_IRQ_EN
        checkOutput("reset_irq", {31'h0, Kbd_Irq}, 32'h0);
`endif
        Req = 1'b0;
        Reset_N = 1'b1;
        applyStimulus("kbsr_after_reset", 1'b0, 16'hFE00, 16'h0, 16'h0000, 1, 1'b0, 16'h0);

        // SRAM write then read with two wait states
        we_cnt = 0; dq_ok_cnt = 0; we_expect = 16'hBEEF;
        applyStimulus("sram_wr_3000", 1'b1, 16'h3000, 16'hBEEF, 16'h0, 4, 1'b0, 16'h0);
        checkOutput("sram_we_cycles", 32'(we_cnt), 32'd3);
        checkOutput("sram_dq_driven", 32'(dq_ok_cnt), 32'd3);
        applyStimulus("sram_rd_3000", 1'b0, 16'h3000, 16'h0, 16'hBEEF, 4, 1'b0, 16'h0);
        we_expect = 16'h1234;
        applyStimulus("sram_wr_0055", 1'b1, 16'h0055, 16'h1234, 16'h0, 4, 1'b0, 16'h0);
        applyStimulus("sram_rd_0055", 1'b0, 16'h0055, 16'h0, 16'h1234, 4, 1'b0, 16'h0);
        applyStimulus("sram_rd_3000b", 1'b0, 16'h3000, 16'h0, 16'hBEEF, 4, 1'b0, 16'h0);

        // Keyboard single key
        pulseStrobe(16'h0041);
        applyStimulus("kbsr_ready", 1'b0, 16'hFE00, 16'h0, 16'h8000, 1, 1'b0, 16'h0);
        applyStimulus("kbdr_0041", 1'b0, 16'hFE02, 16'h0, 16'h0041, 1, 1'b0, 16'h0);
        applyStimulus("kbsr_cleared", 1'b0, 16'hFE00, 16'h0, 16'h0000, 1, 1'b0, 16'h0);

        // Overrun, then a KBDR read colliding with a new strobe
        pulseStrobe(16'h1111);
        pulseStrobe(16'h2222);
        applyStimulus("kbsr_overrun", 1'b0, 16'hFE00, 16'h0, 16'hA000, 1, 1'b0, 16'h0);
        applyStimulus("kbdr_collide", 1'b0, 16'hFE02, 16'h0, 16'h2222, 1, 1'b1, 16'h3333);
        applyStimulus("kbsr_after_collide", 1'b0, 16'hFE00, 16'h0, 16'h8000, 1, 1'b0, 16'h0);
        applyStimulus("kbdr_wr_ignored", 1'b1, 16'hFE02, 16'h9999, 16'h0, 1, 1'b0, 16'h0);
        applyStimulus("kbdr_3333", 1'b0, 16'hFE02, 16'h0, 16'h3333, 1, 1'b0, 16'h0);
        applyStimulus("kbsr_idle", 1'b0, 16'hFE00, 16'h0, 16'h0000, 1, 1'b0, 16'h0);

`ifdef MMIO_KBD_IRQ_EN
        applyStimulus("kbsr_wr_ie", 1'b1, 16'hFE00, 16'h4000, 16'h0, 1, 1'b0, 16'h0);
        applyStimulus("kbsr_ie_rd", 1'b0, 16'hFE00, 16'h0, 16'h4000, 1, 1'b0, 16'h0);
        pulseStrobe(16'h0077);
        checkOutput("irq_set", {31'h0, Kbd_Irq}, 32'h1);
        applyStimulus("kbsr_ie_ready", 1'b0, 16'hFE00, 16'h0, 16'hC000, 1, 1'b0, 16'h0);
        applyStimulus("kbdr_0077", 1'b0, 16'hFE02, 16'h0, 16'h0077, 1, 1'b0, 16'h0);
        @(negedge Clk);
        checkOutput("irq_clr", {31'h0, Kbd_Irq}, 32'h0);
        applyStimulus("kbsr_ie_only", 1'b0, 16'hFE00, 16'h0, 16'h4000, 1, 1'b0, 16'h0);
`else
        applyStimulus("kbsr_wr_ignored", 1'b1, 16'hFE00, 16'h4000, 16'h0, 1, 1'b0, 16'h0);
        applyStimulus("kbsr_no_ie", 1'b0, 16'hFE00, 16'h0, 16'h0000, 1, 1'b0, 16'h0);
`endif

        // Display registers, DSR and unmapped IO
        applyStimulus("ddr0_wr", 1'b1, 16'hFE06, 16'h5A5A, 16'h0, 1, 1'b0, 16'h0);
        checkOutput("disp_in_done0", Disp_Out, 32'h0000_0000);
        @(negedge Clk);
        checkOutput("disp_ddr0", Disp_Out, 32'h0000_5A5A);
        applyStimulus("ddr1_wr", 1'b1, 16'hFE07, 16'h1234, 16'h0, 1, 1'b0, 16'h0);
        checkOutput("disp_in_done1", Disp_Out, 32'h0000_5A5A);
        @(negedge Clk);
        checkOutput("disp_ddr1", Disp_Out, 32'h1234_5A5A);
        applyStimulus("ddr1_rd", 1'b0, 16'hFE07, 16'h0, 16'h1234, 1, 1'b0, 16'h0);
        applyStimulus("dsr_rd", 1'b0, 16'hFE04, 16'h0, 16'h8000, 1, 1'b0, 16'h0);
        applyStimulus("unmapped_wr", 1'b1, 16'hFE20, 16'hFFFF, 16'h0, 1, 1'b0, 16'h0);
        applyStimulus("unmapped_rd", 1'b0, 16'hFE20, 16'h0, 16'h0000, 1, 1'b0, 16'h0);
        checkOutput("disp_unchanged", Disp_Out, 32'h1234_5A5A);

        // Reset in the middle of an SRAM write: no Ready, everything back to idle
        pulseStrobe(16'h0055);
        @(negedge Clk);
        Req = 1'b1; R_W = 1'b1; Addr = 16'h0077; Wdata = 16'hDEAD;
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b0;
        Req = 1'b0;
        @(negedge Clk);
        checkOutput("midrst_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
        checkOutput("midrst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
        checkOutput("midrst_ready", {31'h0, Ready}, 32'h0);
        checkOutput("midrst_disp", Disp_Out, 32'h0);
        checkOutput("midrst_rdata", {16'h0, Rdata}, 32'h0);
        Reset_N = 1'b1;
        last_rd = 16'h0000;
        applyStimulus("midrst_kbsr", 1'b0, 16'hFE00, 16'h0, 16'h0000, 1, 1'b0, 16'h0);
        applyStimulus("midrst_kbdr", 1'b0, 16'hFE02, 16'h0, 16'h0000, 1, 1'b0, 16'h0);

        repeat (3) @(negedge Clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
